lu_row_mem: RTL and testbench
=============================

LU_ROW_MEM -- requirements
Module: lu_row_mem

Interface
REQ-001 SHALL have parameter SIZE, default 16, giving matrix dimension (rows = columns = SIZE); AW = $clog2(SIZE).
REQ-002 SHALL have ports, one per line (name  direction  width  meaning):
  clk_i  in  1  single clock; all logic on rising edge
  rst_i  in  1  reset, synchronous, active-high
  start_i  in  1  begin LOAD phase (sampled in IDLE only)
  load_row_i  in  SIZE*128  host row; element k = {imag,real} FP64 at bits [128k+127:128k]
  load_valid_i  in  1  host row valid
  load_ready_o  out  1  host row accepted when valid&ready
  lu_start_o  out  1  one-cycle start pulse to LU engine
  rd_addr_i  in  AW  LU row read address
  rd_addr_valid_i  in  1  LU read request valid
  rd_row_o  out  SIZE*128  returned row
  rd_row_addr_o  out  AW  address of returned row
  rd_row_valid_o  out  1  returned row valid
  wr_row_i  in  SIZE*128  LU row write data
  wr_addr_i  in  AW  LU row write address
  wr_valid_i  in  1  LU row write valid
  wr_ready_o  out  1  LU row write accepted when valid&ready
  lu_done_i  in  1  LU sequence complete (level, sampled in RUN)
  dump_row_o  out  SIZE*128  result row to host
  dump_addr_o  out  AW  result row index
  dump_valid_o  out  1  result row valid
  dump_ready_i  in  1  host accepts result row
  done_o  out  1  one-cycle pulse, dump finished
  busy_o  out  1  state != IDLE

Function
REQ-003 SHALL store SIZE rows x SIZE complex FP64 elements in registers; storage not cleared by reset.
REQ-004 SHALL implement FSM IDLE -> LOAD -> RUN -> DUMP -> IDLE.
REQ-005 IDLE: start_i=1 -> LOAD next cycle, load counter cleared to 0; all other inputs ignored.
REQ-006 LOAD: load_ready_o=1; each valid&ready writes load_row_i to row[load_cnt], load_cnt+1; handshake with load_cnt=SIZE-1 -> RUN next cycle.
REQ-007 lu_start_o SHALL be 1 for exactly the first cycle in RUN.
REQ-008 RUN: rd_addr_valid_i=1 in cycle N -> rd_row_valid_o=1, rd_row_addr_o=rd_addr_i, rd_row_o=row[rd_addr_i] in cycle N+1 (1-cycle latency, one response per request cycle, no backpressure); rd_addr_valid_i=0 -> rd_row_valid_o=0 next cycle.
REQ-009 RUN: wr_ready_o=1; wr_valid_i=1 writes wr_row_i to row[wr_addr_i] at clock edge.
REQ-010 Same-cycle read and write to same address SHALL return the new (written) data (write-first bypass); different addresses are independent.
REQ-011 Outside RUN: wr_ready_o=0, writes ignored, rd_addr_valid_i ignored, rd_row_valid_o=0 on next cycle.
REQ-012 RUN: lu_done_i=1 -> DUMP next cycle, dump counter cleared; write accepted in that same cycle SHALL still be committed.
REQ-013 DUMP: dump_valid_o=1, dump_addr_o=dump_cnt, dump_row_o=row[dump_cnt] (combinational from storage); held stable until dump_ready_i; handshake increments dump_cnt.
REQ-014 DUMP handshake at dump_cnt=SIZE-1 -> IDLE next cycle with done_o=1 for that one cycle.
REQ-015 Counters SHALL be AW bits wide; no wrap past SIZE-1 occurs since FSM leaves state at SIZE-1.
REQ-016 start_i outside IDLE, load_valid_i outside LOAD, dump_ready_i outside DUMP SHALL have no effect.

Reset
REQ-017 rst_i=1 at clock edge -> state IDLE, load_cnt=dump_cnt=0, load_ready_o=0, lu_start_o=0, rd_row_valid_o=0, wr_ready_o=0, dump_valid_o=0, done_o=0, busy_o=0, rd_row_addr_o=0.
REQ-018 Reset in any state (mid-LOAD, mid-RUN, mid-DUMP) SHALL abort immediately; no partial write committed in the reset cycle.

Verification
REQ-019 SIZE=4: start_i, 4 load handshakes rows r0..r3 (element values = row*4+col) -> lu_start_o pulses once on first RUN cycle.
REQ-020 RUN, rd_addr_i=2 valid one cycle -> next cycle rd_row_valid_o=1, rd_row_addr_o=2, rd_row_o=r2; following cycle rd_row_valid_o=0.
REQ-021 RUN, same cycle wr_addr_i=1 wr_valid_i=1 data X and rd_addr_i=1 -> next cycle rd_row_o=X.
REQ-022 lu_done_i with dump_ready_i toggling 1,0,1,1,1 -> rows 0..3 emitted in order, data stable during stall, done_o pulses after row 3, busy_o=0.
REQ-023 rst_i asserted after 2 of 4 load handshakes -> IDLE, all outputs at reset values; new start_i reloads from row 0.
REQ-024 In LOAD/IDLE, wr_valid_i with new data to row 0 -> row 0 unchanged at dump.

Source files
------------

// File: rtl/lu_row_mem.sv
// lu_row_mem: register-file row store sequencing host load, LU engine access and result dump
module lu_row_mem #(
    parameter int SIZE = 16,
    localparam int AW = $clog2(SIZE),
    localparam int RW = SIZE * 128
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic [RW-1:0] load_row_i,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    output logic          lu_start_o,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_addr_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_row_addr_o,
    output logic          rd_row_valid_o,
    input  logic [RW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_valid_i,
    output logic          wr_ready_o,
    input  logic          lu_done_i,
    output logic [RW-1:0] dump_row_o,
    output logic [AW-1:0] dump_addr_o,
    output logic          dump_valid_o,
    input  logic          dump_ready_i,
    output logic          done_o,
    output logic          busy_o
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DUMP} state_t;
    localparam logic [AW-1:0] LAST = AW'(SIZE - 1);
    state_t state, state_n;
    logic [AW-1:0] load_cnt, dump_cnt;
    logic [RW-1:0] mem [SIZE];
    logic rd_fire;
    assign load_ready_o = state == LOAD;
    assign wr_ready_o   = state == RUN;
    assign dump_valid_o = state == DUMP;
    assign busy_o       = state != IDLE;
    assign dump_addr_o  = dump_cnt;
    assign dump_row_o   = mem[dump_cnt];
    assign rd_fire      = state == RUN && rd_addr_valid_i;
    // Next-state: each phase ends on its last handshake or on lu_done_i
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start_i ? LOAD : IDLE;
            LOAD:    state_n = (load_valid_i && load_cnt == LAST) ? RUN : LOAD;
            RUN:     state_n = lu_done_i ? DUMP : RUN;
            DUMP:    state_n = (dump_ready_i && dump_cnt == LAST) ? IDLE : DUMP;
            default: state_n = IDLE;
        endcase
    end
    // Control state, row counters, one-cycle pulses and read-response handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            load_cnt       <= '0;
            dump_cnt       <= '0;
            lu_start_o     <= 1'b0;
            done_o         <= 1'b0;
            rd_row_valid_o <= 1'b0;
            rd_row_addr_o  <= '0;
        end else begin
            state          <= state_n;
            load_cnt       <= (state == IDLE) ? '0 : (state == LOAD && load_valid_i) ? load_cnt + 1'b1 : load_cnt;
            dump_cnt       <= (state == RUN) ? '0 : (state == DUMP && dump_ready_i) ? dump_cnt + 1'b1 : dump_cnt;
            lu_start_o     <= state == LOAD && state_n == RUN;
            done_o         <= state == DUMP && state_n == IDLE;
            rd_row_valid_o <= rd_fire;
            if (rd_fire) rd_row_addr_o <= rd_addr_i;
        end
    end
    // Read data register; a same-address write in the request cycle is forwarded
    always_ff @(posedge clk_i) begin
        if (!rst_i && rd_fire) rd_row_o <= (wr_valid_i && wr_addr_i == rd_addr_i) ? wr_row_i : mem[rd_addr_i];
    end
    // Row storage: host rows in LOAD, engine rows in RUN, nothing during reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && load_ready_o && load_valid_i) mem[load_cnt] <= load_row_i;
        else if (!rst_i && wr_ready_o && wr_valid_i) mem[wr_addr_i] <= wr_row_i;
    end
endmodule

// File: tb/tb_lu_row_mem.sv
// tb_lu_row_mem: directed vector table plus reset corner sequences for lu_row_mem (SIZE=4)
module tb_lu_row_mem;
    localparam int SIZE = 4;
    localparam int AW = 2;
    localparam int RW = SIZE * 128;

    logic clk_i = 1'b0;
    logic rst_i, start_i, load_valid_i, load_ready_o, lu_start_o;
    logic [RW-1:0] load_row_i, rd_row_o, wr_row_i, dump_row_o;
    logic [AW-1:0] rd_addr_i, rd_row_addr_o, wr_addr_i, dump_addr_o;
    logic rd_addr_valid_i, rd_row_valid_o, wr_valid_i, wr_ready_o, lu_done_i;
    logic dump_valid_o, dump_ready_i, done_o, busy_o;

    lu_row_mem #(.SIZE(SIZE)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .load_row_i(load_row_i), .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
        .lu_start_o(lu_start_o),
        .rd_addr_i(rd_addr_i), .rd_addr_valid_i(rd_addr_valid_i),
        .rd_row_o(rd_row_o), .rd_row_addr_o(rd_row_addr_o), .rd_row_valid_o(rd_row_valid_o),
        .wr_row_i(wr_row_i), .wr_addr_i(wr_addr_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
        .lu_done_i(lu_done_i),
        .dump_row_o(dump_row_o), .dump_addr_o(dump_addr_o), .dump_valid_o(dump_valid_o),
        .dump_ready_i(dump_ready_i), .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        string nm;
        int rst, start, lv, lsel, rv, ra, wv, wa, wsel, ldone, dr;
        int lr, lus, rvo, rao, rsel, wr, dv, da, dsel, dn, bsy;
    } vec_t;

    logic [RW-1:0] pat [8];
    vec_t tbl [$];
    int nvec = 0;
    int errs = 0;

    // Row whose element c holds {imag=0, real=base+c} as FP64
    function automatic logic [RW-1:0] mkrow(int base);
        logic [RW-1:0] r;
        for (int c = 0; c < SIZE; c++) r[128*c +: 128] = {64'h0, $realtobits(real'(base + c))};
        return r;
    endfunction

    task automatic chk(string nm, logic [RW-1:0] act, logic [RW-1:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst_i = 0; start_i = 0; load_valid_i = 0; load_row_i = '0; rd_addr_valid_i = 0; rd_addr_i = '0;
        wr_valid_i = 0; wr_addr_i = '0; wr_row_i = '0; lu_done_i = 0; dump_ready_i = 0;
    endtask

    task automatic apply(vec_t v);
        @(negedge clk_i);
        rst_i = v.rst != 0; start_i = v.start != 0; load_valid_i = v.lv != 0; load_row_i = pat[v.lsel];
        rd_addr_valid_i = v.rv != 0; rd_addr_i = AW'(v.ra);
        wr_valid_i = v.wv != 0; wr_addr_i = AW'(v.wa); wr_row_i = pat[v.wsel];
        lu_done_i = v.ldone != 0; dump_ready_i = v.dr != 0;
        #1;
        nvec++;
        chk({v.nm, ".load_ready"}, RW'(load_ready_o), RW'(v.lr));
        chk({v.nm, ".lu_start"}, RW'(lu_start_o), RW'(v.lus));
        chk({v.nm, ".rd_valid"}, RW'(rd_row_valid_o), RW'(v.rvo));
        if (v.rvo != 0) chk({v.nm, ".rd_addr"}, RW'(rd_row_addr_o), RW'(v.rao));
        if (v.rsel >= 0) chk({v.nm, ".rd_row"}, rd_row_o, pat[v.rsel]);
        chk({v.nm, ".wr_ready"}, RW'(wr_ready_o), RW'(v.wr));
        chk({v.nm, ".dump_valid"}, RW'(dump_valid_o), RW'(v.dv));
        if (v.dv != 0) chk({v.nm, ".dump_addr"}, RW'(dump_addr_o), RW'(v.da));
        if (v.dsel >= 0) chk({v.nm, ".dump_row"}, dump_row_o, pat[v.dsel]);
        chk({v.nm, ".done"}, RW'(done_o), RW'(v.dn));
        chk({v.nm, ".busy"}, RW'(busy_o), RW'(v.bsy));
    endtask

    // Start and load rows 0..3 with r0..r3; returns in the first RUN cycle with inputs idle
    task automatic load_all();
        @(negedge clk_i); start_i = 1;
        @(negedge clk_i); start_i = 0;
        for (int r = 0; r < SIZE; r++) begin
            @(negedge clk_i); load_valid_i = 1; load_row_i = pat[r];
        end
        @(negedge clk_i); load_valid_i = 0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) pat[i] = mkrow(i < 4 ? 4 * i : 100 * (i - 3));
        //            nm             rst st lv ls rv ra wv wa ws ld dr | lr us rv ra rs wr dv da ds dn by
        tbl.push_back('{"rst_state",  0, 0, 0, 0, 0, 0, 1, 0, 5, 0, 0,  0, 0, 0, 0,-1, 0, 0, 0,-1, 0, 0});
        tbl.push_back('{"idle_start", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1,  0, 0, 0, 0,-1, 0, 0, 0,-1, 0, 0});
        tbl.push_back('{"junk_load0", 0, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"junk_load1", 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"rst_in_load",1, 0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"after_rst",  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0,-1, 0, 0, 0,-1, 0, 0});
        tbl.push_back('{"restart",    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,-1, 0, 0, 0,-1, 0, 0});
        tbl.push_back('{"load_r0",    0, 0, 1, 0, 0, 0, 1, 0, 5, 1, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"load_stall", 0, 0, 0, 5, 1, 2, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"load_r1",    0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"load_r2",    0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"load_r3",    0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0,-1, 0, 0, 0,-1, 0, 1});
        tbl.push_back('{"run_first",  0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0,  0, 1, 0, 0,-1, 1, 0, 0,-1, 0, 1});
        tbl.push_back('{"read_r2",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 2, 2, 1, 0, 0,-1, 0, 1});
        tbl.push_back('{"rd_idle_wr", 0, 0, 0, 0, 1, 1, 1, 1, 4, 0, 0,  0, 0, 0, 0,-1, 1, 0, 0,-1, 0, 1});
        tbl.push_back('{"bypass",     0, 0, 0, 0, 1, 3, 1, 2, 6, 0, 0,  0, 0, 1, 1, 4, 1, 0, 0,-1, 0, 1});
        tbl.push_back('{"diff_addr",  0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0,  0, 0, 1, 3, 3, 1, 0, 0,-1, 0, 1});
        tbl.push_back('{"done_wr",    0, 0, 0, 0, 1, 0, 1, 3, 7, 1, 0,  0, 0, 1, 2, 6, 1, 0, 0,-1, 0, 1});
        tbl.push_back('{"dump0",      0, 1, 0, 0, 1, 1, 1, 0, 5, 0, 1,  0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1});
        tbl.push_back('{"dump1_stall",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,-1, 0, 1, 1, 4, 0, 1});
        tbl.push_back('{"dump1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,-1, 0, 1, 1, 4, 0, 1});
        tbl.push_back('{"dump2",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,-1, 0, 1, 2, 6, 0, 1});
        tbl.push_back('{"dump3",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0,-1, 0, 1, 3, 7, 0, 1});
        tbl.push_back('{"done_pulse", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,-1, 0, 0, 0,-1, 1, 0});
        tbl.push_back('{"done_clear", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,-1, 0, 0, 0,-1, 0, 0});

        idle_inputs();
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        foreach (tbl[i]) apply(tbl[i]);

        // Back-to-back reads, then reset in RUN with a write that must not leave RUN state behind
        idle_inputs();
        load_all();
        nvec++;
        chk("seq_a.lu_start", RW'(lu_start_o), RW'(1));
        rd_addr_valid_i = 1; rd_addr_i = 2'd3;
        @(negedge clk_i); rd_addr_i = 2'd0; #1;
        nvec++;
        chk("seq_a.lu_start_once", RW'(lu_start_o), RW'(0));
        chk("seq_a.rd3_addr", RW'(rd_row_addr_o), RW'(3));
        chk("seq_a.rd3_row", rd_row_o, pat[3]);
        @(negedge clk_i); rd_addr_valid_i = 0; #1;
        nvec++;
        chk("seq_a.rd0_valid", RW'(rd_row_valid_o), RW'(1));
        chk("seq_a.rd0_row", rd_row_o, pat[0]);
        @(negedge clk_i); rst_i = 1; wr_valid_i = 1; wr_addr_i = 2'd0; wr_row_i = pat[4]; rd_addr_valid_i = 1; #1;
        nvec++;
        chk("seq_a.busy_pre_rst", RW'(busy_o), RW'(1));
        @(negedge clk_i); idle_inputs(); #1;
        nvec++;
        chk("seq_a.rst_busy", RW'(busy_o), RW'(0));
        chk("seq_a.rst_wr_ready", RW'(wr_ready_o), RW'(0));
        chk("seq_a.rst_rd_valid", RW'(rd_row_valid_o), RW'(0));
        chk("seq_a.rst_rd_addr", RW'(rd_row_addr_o), RW'(0));

        // Reset in the middle of DUMP after one row was accepted
        load_all();
        lu_done_i = 1;
        @(negedge clk_i); lu_done_i = 0; #1;
        nvec++;
        chk("seq_b.dump_valid", RW'(dump_valid_o), RW'(1));
        chk("seq_b.dump0_row", dump_row_o, pat[0]);
        dump_ready_i = 1;
        @(negedge clk_i); dump_ready_i = 0; rst_i = 1; #1;
        nvec++;
        chk("seq_b.dump1_addr", RW'(dump_addr_o), RW'(1));
        chk("seq_b.dump1_row", dump_row_o, pat[1]);
        @(negedge clk_i); rst_i = 0; #1;
        nvec++;
        chk("seq_b.rst_dump_valid", RW'(dump_valid_o), RW'(0));
        chk("seq_b.rst_busy", RW'(busy_o), RW'(0));
        chk("seq_b.rst_done", RW'(done_o), RW'(0));
        chk("seq_b.rst_load_ready", RW'(load_ready_o), RW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
